wb_arbiter: RTL and testbench

- Writer end of the general-purpose register file's single write port (RegWr/W_Reg/W_data).
- Merges two result sources into one registered write per cycle:
  - the single-cycle ALU path, which has fixed priority;
  - the multi-cycle mult/div unit (MDU), whose results are buffered in a small FIFO.
- Exports a pending-write lookup so decode can stall on registers with queued MDU results.

---
 rtl/wb_arbiter.sv | 96 +++++++++
 tb/tb_wb_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results have fixed priority, and MDU
// results wait in a small FIFO that drains whenever the ALU leaves the port idle.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_reg,
    input  logic [DW-1:0]            alu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [AW-1:0]            mdu_reg,
    input  logic [DW-1:0]            mdu_data,
    input  logic [AW-1:0]            chk_reg,
    output logic                     chk_hit,
    output logic                     RegWr,
    output logic [AW-1:0]            W_Reg,
    output logic [DW-1:0]            W_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] fifo_reg  [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;

    logic alu_take;
    logic push;
    logic pop;
    logic [DEPTH-1:0] hit_vec;

    assign mdu_ready = (count_reg < (PW+1)'(DEPTH));
    assign alu_take  = alu_valid && (alu_reg != '0);
    // Index-0 MDU results complete the handshake but are never stored.
    assign push      = mdu_valid && mdu_ready && (mdu_reg != '0);
    assign pop       = !alu_take && (count_reg != '0);
    assign count     = count_reg;

    // A slot is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - rd_ptr_reg;
            assign hit_vec[gi] = ({1'b0, offset} < count_reg) && (fifo_reg[gi] == chk_reg);
        end
    endgenerate

    assign chk_hit = (|hit_vec) && (chk_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr_reg]  <= mdu_reg;
            fifo_data[wr_ptr_reg] <= mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // W_Reg/W_data keep their last value in idle cycles; only RegWr drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWr  <= 1'b0;
            W_Reg  <= '0;
            W_data <= '0;
        end else if (alu_take) begin
            RegWr  <= 1'b1;
            W_Reg  <= alu_reg;
            W_data <= alu_data;
        end else if (pop) begin
            RegWr  <= 1'b1;
            W_Reg  <= fifo_reg[rd_ptr_reg];
            W_data <= fifo_data[rd_ptr_reg];
        end else begin
            RegWr  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU priority, FIFO buffering/drain order,
// full-FIFO handshake, index-0 suppression, chk_hit and async reset.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_reg;
    logic [31:0] mdu_data;
    logic [4:0]  chk_reg;
    logic        chk_hit;
    logic        RegWr;
    logic [4:0]  W_Reg;
    logic [31:0] W_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_reg(mdu_reg), .mdu_data(mdu_data),
        .chk_reg(chk_reg), .chk_hit(chk_hit),
        .RegWr(RegWr), .W_Reg(W_Reg), .W_data(W_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 0; alu_reg = 0; alu_data = 0;
        mdu_valid = 0; mdu_reg = 0; mdu_data = 0; chk_reg = 0;
        #1;
        chk("rst_regwr", RegWr, 0);
        chk("rst_wreg", W_Reg, 0);
        chk("rst_wdata", W_data, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", mdu_ready, 1);
        chk("rst_hit", chk_hit, 0);
        tick(); tick();
        rst_n = 1'b1;

        // ALU single write, 1-cycle latency
        alu_valid = 1; alu_reg = 3; alu_data = 32'h1234;
        tick();
        alu_valid = 0;
        chk("alu_regwr", RegWr, 1);
        chk("alu_wreg", W_Reg, 3);
        chk("alu_wdata", W_data, 32'h1234);
        tick();
        chk("alu_idle", RegWr, 0);

        // Single MDU push, no bypass
        mdu_valid = 1; mdu_reg = 5; mdu_data = 32'hAAAA5555; chk_reg = 5;
        tick();
        mdu_valid = 0;
        chk("mdu_count1", count, 1);
        chk("mdu_hit1", chk_hit, 1);
        chk("mdu_nobypass", RegWr, 0);
        tick();
        chk("mdu_regwr", RegWr, 1);
        chk("mdu_wreg", W_Reg, 5);
        chk("mdu_wdata", W_data, 32'hAAAA5555);
        chk("mdu_count0", count, 0);
        chk("mdu_hit0", chk_hit, 0);
        tick();
        chk("mdu_idle", RegWr, 0);

        // ALU busy every cycle while MDU offers 5 results
        chk_reg = 12;
        for (int i = 0; i < 8; i++) begin
            alu_valid = 1; alu_reg = 5'(i + 1); alu_data = 32'h100 + i;
            mdu_valid = 1;
            mdu_reg = (i < 4) ? 5'(10 + i) : 5'd14;
            mdu_data = (i < 4) ? 32'hD0 + i : 32'hD4;
            #1;
            chk($sformatf("busy_ready%0d", i), mdu_ready, (i < 4) ? 1 : 0);
            tick();
            chk($sformatf("busy_wreg%0d", i), W_Reg, i + 1);
            chk($sformatf("busy_wdata%0d", i), W_data, 32'h100 + i);
        end
        chk("busy_count", count, 4);
        chk("busy_hit12", chk_hit, 1);

        // ALU stops: pop while full, mdu_ready stays 0 that cycle
        alu_valid = 0;
        #1;
        chk("full_ready0", mdu_ready, 0);
        tick();
        chk("drain_w10", W_Reg, 10);
        chk("drain_d10", W_data, 32'hD0);
        chk("drain_cnt3", count, 3);
        chk("drain_ready1", mdu_ready, 1);
        tick();
        mdu_valid = 0;
        chk("drain_w11", W_Reg, 11);
        chk("drain_cnt3b", count, 3);
        tick();
        chk("drain_w12", W_Reg, 12);
        chk("drain_cnt2", count, 2);
        tick();
        chk("drain_w13", W_Reg, 13);
        tick();
        chk("drain_w14", W_Reg, 14);
        chk("drain_d14", W_data, 32'hD4);
        chk("drain_regwr", RegWr, 1);
        chk("drain_cnt0", count, 0);
        chk("stale_hit12", chk_hit, 0);
        tick();
        chk("drain_idle", RegWr, 0);

        // Index 0 on both sources
        alu_valid = 1; alu_reg = 0; alu_data = 32'hFFFF;
        mdu_valid = 1; mdu_reg = 0; mdu_data = 32'hEEEE; chk_reg = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("zero_regwr%0d", i), RegWr, 0);
            chk($sformatf("zero_count%0d", i), count, 0);
            chk($sformatf("zero_hit%0d", i), chk_hit, 0);
        end

        // ALU reg 0 lets the FIFO drain
        mdu_reg = 7; mdu_data = 32'h77;
        tick();
        mdu_valid = 0;
        chk("z_drain_cnt", count, 1);
        tick();
        alu_valid = 0;
        chk("z_drain_wreg", W_Reg, 7);
        chk("z_drain_wdata", W_data, 32'h77);
        chk("z_drain_cnt0", count, 0);

        // Fill 3 entries behind ALU traffic, then reset mid-drain
        alu_valid = 1; alu_reg = 9; alu_data = 32'h99; chk_reg = 21;
        for (int i = 0; i < 3; i++) begin
            mdu_valid = 1; mdu_reg = 5'(20 + i); mdu_data = 32'h200 + i;
            tick();
        end
        alu_valid = 0; mdu_valid = 0;
        chk("fill_cnt3", count, 3);
        tick();
        chk("fill_w20", W_Reg, 20);
        chk("fill_cnt2", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_regwr", RegWr, 0);
        chk("mid_rst_wreg", W_Reg, 0);
        chk("mid_rst_wdata", W_data, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_hit", chk_hit, 0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_regwr%0d", i), RegWr, 0);
            chk($sformatf("post_rst_count%0d", i), count, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
